pulse_stretcher: RTL and testbench

//  Inverse of the button edge-detect path: turns single-cycle event pulses back into

---
 rtl/pulse_pkg.sv | 21 ++
 rtl/cycle_timer.sv | 40 ++++
 rtl/pulse_stretcher.sv | 155 +++++++++++++++
 tb/tb_pulse_stretcher.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Purpose : shared types and board defaults for the LED pulse stretcher.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  // 50 ms blink and 50 ms dark gap on a 100 MHz board clock.
  localparam int DEF_ON_CYCLES  = 5_000_000;
  localparam int DEF_GAP_CYCLES = 5_000_000;
  localparam int DEF_PEND_W     = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Purpose : loadable down-counter that parks at zero; zero_o flags the terminal count.
// Latency : load takes effect on the next clock edge; zero_o is combinational from the count.
// Backpressure: none; counts every cycle it is not loaded.
// Ports   : clk, rst_n (async active-low), load_i/load_val_i (load request and value),
//           value_o (current count), zero_o (count == 0).
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Purpose : stretches single-cycle event strobes into fixed-width LED blinks with a dark gap,
//           queueing events that arrive mid-blink and replaying them in order.
// Latency : pulse_in in cycle N drives led_out high in cycles N+1..N+ON_CYCLES when idle.
// Backpressure: none upstream; events beyond the saturated pending count are dropped and
//           flagged on the sticky overflow output.
// Ports   : clk, reset (async active-low), pulse_in (event strobe), clear (sync queue/overflow
//           clear), led_out, busy, pending (queued blinks), overflow (sticky drop flag).
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int TW = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  stretch_state_t    state_q, state_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic [TW-1:0]     tmr_value;
  logic              tmr_zero;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;

  logic evt;
  logic gap_term;
  logic from_queue;
  logic direct;
  logic inc;
  logic dec;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  // A clear in the same cycle swallows the strobe entirely.
  assign evt        = pulse_in & ~clear;
  assign gap_term   = (state_q == GAP) && tmr_zero;
  // A clear on the GAP terminal cycle empties the queue, so nothing is replayed.
  assign from_queue = gap_term && (pend_q != '0) && !clear;
  // The strobe starts a blink itself only when nothing is waiting ahead of it.
  assign direct     = evt && ((state_q == IDLE) || (gap_term && (pend_q == '0)));
  assign inc        = evt && !direct;
  assign dec        = from_queue;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and timer load
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = ON_LOAD;
    case (state_q)
      IDLE: begin
        if (evt) begin
          state_d  = ON;
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end
      end
      ON: begin
        if (tmr_zero) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          if (from_queue || evt) begin
            state_d  = ON;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so they can be registered without extra lag.
  always_comb begin
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  // Pending counter; simultaneous inc and dec cancel.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (inc && !dec) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Purpose : randomized + directed bench with a timeline reference model and output scoreboard.
// Latency : expectations are queued one cycle ahead of the DUT registers they describe.
// Backpressure: n/a.
module tb_pulse_stretcher;

  localparam int ON   = 4;
  localparam int GAP  = 3;
  localparam int PW   = 2;
  localparam int PMAX = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pulse_in = 1'b0;
  logic          clear = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  pulse_stretcher #(
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .clear    (clear),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   t;
    logic led;
    logic bsy;
    int   pend;
    logic ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a blink is a time window [start, start+ON+GAP-1] with the
  // LED lit for its first ON cycles; queued events are a plain count.
  bit m_valid = 1'b0;
  int m_start = 0;
  int m_pend  = 0;
  bit m_ovf   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit model_terminal(input int t);
    return m_valid && (t == m_start + ON + GAP - 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pend  = 0;
    m_ovf   = 1'b0;
  endtask

  // Apply inputs seen in cycle t and queue the outputs expected in cycle t+1.
  task automatic model_step(input bit p, input bit c, input int t);
    exp_t e;
    bit   terminal;
    bit   idle;
    terminal = model_terminal(t);
    idle     = !m_valid || (t > m_start + ON + GAP - 1);
    if (c) begin
      m_pend = 0;
      m_ovf  = 1'b0;
      if (terminal) m_valid = 1'b0;
    end else if (idle) begin
      if (p) begin
        m_valid = 1'b1;
        m_start = t + 1;
      end
    end else if (terminal) begin
      if (m_pend > 0) begin
        m_start = t + 1;
        if (!p) m_pend--;
      end else if (p) begin
        m_start = t + 1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (p) begin
      if (m_pend == PMAX) m_ovf = 1'b1;
      else m_pend++;
    end
    e.t    = t + 1;
    e.led  = m_valid && (t + 1 >= m_start) && (t + 1 <= m_start + ON - 1);
    e.bsy  = m_valid && (t + 1 <= m_start + ON + GAP - 1);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    q.push_back(e);
  endtask

  task automatic step(input bit p, input bit c);
    @(posedge clk);
    #1;
    pulse_in = p;
    clear    = c;
    model_step(p, c, cyc);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Pulse exactly on the next GAP terminal cycle, within a bounded wait.
  task automatic pulse_at_terminal();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit      = model_terminal(cyc);
      pulse_in = hit;
      clear    = 1'b0;
      model_step(hit, 1'b0, cyc);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL gap_terminal_wait: got no terminal cycle expected one within 30 cycles");
    end
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    pulse_in = 1'b0;
    clear    = 1'b0;
    reset    = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("async_rst_led", int'(led_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_pending", int'(pending), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // Monitor: compare whenever the DUT presents the cycle a queued expectation targets.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].t < cyc) begin
        e = q.pop_front();
        chk("stale_expectation", cyc, e.t);
      end else if (q.size() > 0 && q[0].t == cyc) begin
        e = q.pop_front();
        chk("led_out", int'(led_out), int'(e.led));
        chk("busy", int'(busy), int'(e.bsy));
        chk("pending", int'(pending), e.pend);
        chk("overflow", int'(overflow), int'(e.ovf));
      end
    end
  end

  initial begin
    bit p;
    bit c;
    #1;
    chk("reset_led", int'(led_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_overflow", int'(overflow), 0);
    #22;
    reset = 1'b1;
    idle_n(3);

    // Single pulse
    step(1'b1, 1'b0);
    idle_n(10);

    // Back-to-back pulses queue two blinks
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle_n(22);

    // Saturation and sticky overflow
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle_n(40);

    // Pulse on GAP terminal with a full queue, then with an empty queue
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    pulse_at_terminal();
    idle_n(40);
    step(1'b1, 1'b0);
    pulse_at_terminal();
    idle_n(12);

    // Clear during the second blink with pending=2, overflow=1
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle_n(4);
    step(1'b0, 1'b1);
    idle_n(20);

    // Async reset in the middle of a blink with a loaded queue
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    async_reset_check();
    step(1'b1, 1'b0);
    idle_n(10);

    // Randomized traffic, biased toward pulses on GAP terminal cycles
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (model_terminal(cyc)) p = ($urandom_range(0, 1) == 1);
      else p = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 59) == 0);
      pulse_in = p;
      clear    = c;
      model_step(p, c, cyc);
    end
    idle_n(30);
    @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
